// File: rtl/snes_load_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snes_load_pkg                                                        |
// | Shared types, address-space codes and mask helpers for the loader.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package snes_load_pkg;

    typedef enum logic [1:0] {
        TOP_IDLE    = 2'd0,
        TOP_LOADING = 2'd1,
        TOP_FLUSH   = 2'd2,
        TOP_DONE    = 2'd3
    } top_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_ISSUE = 2'd1,
        ENG_GUARD = 2'd2,
        ENG_WAITB = 2'd3
    } eng_state_t;

    localparam logic [7:0] SPACE_ROM  = 8'h00;
    localparam logic [7:0] SPACE_CFG  = 8'hFE;
    localparam logic [7:0] SPACE_CTRL = 8'hFF;
    localparam int         RAM_CODE_MAX = 10;

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
    } load_word_t;

    function automatic logic [23:0] ram_mask_of(input logic [7:0] code);
        logic [3:0] c;
        c = (code > 8'(RAM_CODE_MAX)) ? 4'(RAM_CODE_MAX) : code[3:0];
        if (c == 4'd0) begin
            return 24'h000000;
        end
        return (24'd1024 << c) - 24'd1;
    endfunction

    // Every bit at or below the most significant set bit becomes 1.
    function automatic logic [23:0] smear(input logic [23:0] x);
        logic [23:0] m;
        for (int i = 0; i < 24; i++) begin
            m[i] = |(x >> i);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snes_load_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snes_load_ctrl_if                                                    |
// | SPI byte bus in, SDRAM load port and core status out.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface snes_load_ctrl_if;
    logic        spi_wr;
    logic [31:0] spi_addr;
    logic [7:0]  spi_data;
    logic        ram_busy;
    logic [24:0] load_addr;
    logic [15:0] load_data;
    logic        load_wr;
    logic        load_done;
    logic        sys_reset;
    logic [7:0]  rom_type;
    logic [23:0] rom_mask;
    logic [23:0] ram_mask;
    logic        overflow;
    logic [15:0] checksum;

    modport slave (
        input  spi_wr, spi_addr, spi_data, ram_busy,
        output load_addr, load_data, load_wr, load_done, sys_reset,
               rom_type, rom_mask, ram_mask, overflow, checksum
    );

    modport master (
        output spi_wr, spi_addr, spi_data, ram_busy,
        input  load_addr, load_data, load_wr, load_done, sys_reset,
               rom_type, rom_mask, ram_mask, overflow, checksum
    );
endinterface
`default_nettype wire

// File: rtl/snes_load_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snes_load_fifo                                                       |
// | Synchronous word+address FIFO with push, pop, clear, full and empty. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module snes_load_fifo
    import snes_load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clr,
    input  wire logic       i_push,
    input  load_word_t      i_push_word,
    input  wire logic       i_pop,
    output load_word_t      o_head,
    output logic            o_full,
    output logic            o_empty
);
    localparam int AW = $clog2(DEPTH);

    load_word_t    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/snes_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snes_load_ctrl                                                       |
// | Streams ROM bytes from the SPI bus into SDRAM as 16-bit word writes. |
// | Optional macro LOAD_CHECKSUM_EN builds the ROM byte checksum.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module snes_load_ctrl
    import snes_load_pkg::*;
#(
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_GUARD      = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    snes_load_ctrl_if.slave     bus
);
    localparam int GW = (C_GUARD > 1) ? $clog2(C_GUARD) : 1;

    top_state_t  r_top, w_top_next;
    eng_state_t  r_eng, w_eng_next;
    logic        r_spi_wr_d, r_ev;
    logic [31:0] r_ev_addr;
    logic [7:0]  r_ev_data;
    logic        r_pending, r_overflow, r_load_wr;
    logic [7:0]  r_low, r_rom_type;
    logic [22:0] r_low_word;
    logic [23:0] r_max_off, r_rom_mask, r_ram_mask;
    logic [24:0] r_load_addr;
    logic [15:0] r_load_data;
    logic [GW-1:0] r_guard_cnt;

    logic        w_push, w_fifo_clr, w_load_req, w_rom_acc, w_done_enter, w_issue;
    logic        w_fifo_full, w_fifo_empty;
    load_word_t  w_push_word, w_head;

    wire logic [7:0]  w_space     = r_ev_addr[31:24];
    wire logic [23:0] w_off       = r_ev_addr[23:0];
    wire logic        w_is_rom    = r_ev && (w_space == SPACE_ROM);
    wire logic        w_is_cfg    = r_ev && (w_space == SPACE_CFG);
    wire logic        w_ctrl_load = r_ev && (w_space == SPACE_CTRL) &&  r_ev_data[0];
    wire logic        w_ctrl_fin  = r_ev && (w_space == SPACE_CTRL) && !r_ev_data[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spi_wr_d <= 1'b0;
            r_ev       <= 1'b0;
            r_ev_addr  <= '0;
            r_ev_data  <= '0;
        end else begin
            r_spi_wr_d <= bus.spi_wr;
            r_ev       <= bus.spi_wr && !r_spi_wr_d;
            if (bus.spi_wr && !r_spi_wr_d) begin
                r_ev_addr <= bus.spi_addr;
                r_ev_data <= bus.spi_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_top <= TOP_IDLE;
            r_eng <= ENG_IDLE;
        end else begin
            r_top <= w_top_next;
            r_eng <= w_eng_next;
        end
    end

    always_comb begin
        w_top_next   = r_top;
        w_push       = 1'b0;
        w_push_word  = '0;
        w_fifo_clr   = 1'b0;
        w_load_req   = 1'b0;
        w_rom_acc    = 1'b0;
        w_done_enter = 1'b0;
        case (r_top)
            TOP_IDLE, TOP_DONE: begin
                if (w_ctrl_load) begin
                    w_top_next = TOP_LOADING;
                    w_load_req = 1'b1;
                end
            end
            TOP_LOADING: begin
                if (w_ctrl_load) begin
                    w_load_req = 1'b1;
                end else if (w_ctrl_fin) begin
                    w_top_next = TOP_FLUSH;
                end else if (w_is_rom) begin
                    w_rom_acc = 1'b1;
                    if (w_off[0]) begin
                        w_push      = 1'b1;
                        w_push_word = '{addr: {1'b0, w_off[23:1], 1'b0},
                                        data: {r_ev_data, r_pending ? r_low : 8'hFF}};
                    end
                end
            end
            TOP_FLUSH: begin
                if (w_ctrl_load) begin
                    w_top_next = TOP_LOADING;
                    w_load_req = 1'b1;
                    w_fifo_clr = 1'b1;
                end else if (r_pending) begin
                    w_push      = 1'b1;
                    w_push_word = '{addr: {1'b0, r_low_word, 1'b0}, data: {8'hFF, r_low}};
                end else if (w_fifo_empty && (r_eng == ENG_IDLE)) begin
                    w_top_next   = TOP_DONE;
                    w_done_enter = 1'b1;
                end
            end
            default: w_top_next = TOP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_low      <= '0;
            r_low_word <= '0;
            r_max_off  <= '0;
            r_overflow <= 1'b0;
            r_rom_type <= '0;
            r_rom_mask <= '0;
            r_ram_mask <= '0;
        end else begin
            if (w_load_req) begin
                r_pending  <= 1'b0;
                r_max_off  <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_rom_acc) begin
                    if (!w_off[0]) begin
                        r_low      <= r_ev_data;
                        r_low_word <= w_off[23:1];
                        r_pending  <= 1'b1;
                    end else begin
                        r_pending <= 1'b0;
                    end
                    if (w_off > r_max_off) begin
                        r_max_off <= w_off;
                    end
                end else if (w_push) begin
                    r_pending <= 1'b0;
                end
                if (w_push && w_fifo_full) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_done_enter) begin
                r_rom_mask <= smear(r_max_off);
            end
            if (w_is_cfg) begin
                if (!r_ev_addr[0]) begin
                    r_rom_type <= r_ev_data;
                end else begin
                    r_ram_mask <= ram_mask_of(r_ev_data);
                end
            end
        end
    end

    snes_load_fifo #(.DEPTH(C_FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_clr       (w_fifo_clr),
        .i_push      (w_push),
        .i_push_word (w_push_word),
        .i_pop       (w_issue),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // An abort can empty the FIFO under a waiting ISSUE; fall back to IDLE then.
    always_comb begin
        w_eng_next = r_eng;
        w_issue    = 1'b0;
        case (r_eng)
            ENG_IDLE:  if (!w_fifo_empty) w_eng_next = ENG_ISSUE;
            ENG_ISSUE: begin
                if (w_fifo_empty) begin
                    w_eng_next = ENG_IDLE;
                end else if (!bus.ram_busy) begin
                    w_issue    = 1'b1;
                    w_eng_next = ENG_GUARD;
                end
            end
            ENG_GUARD: if (r_guard_cnt == GW'(C_GUARD - 1)) w_eng_next = ENG_WAITB;
            ENG_WAITB: if (!bus.ram_busy) w_eng_next = ENG_IDLE;
            default:   w_eng_next = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_guard_cnt <= '0;
            r_load_wr   <= 1'b0;
            r_load_addr <= '0;
            r_load_data <= '0;
        end else begin
            r_guard_cnt <= (r_eng == ENG_GUARD) ? r_guard_cnt + 1'b1 : '0;
            r_load_wr   <= w_issue;
            if (w_issue) begin
                r_load_addr <= w_head.addr;
                r_load_data <= w_head.data;
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] r_checksum;
    always_ff @(posedge clk) begin
        if (reset || w_load_req) begin
            r_checksum <= '0;
        end else if (w_rom_acc) begin
            r_checksum <= r_checksum + {8'h00, r_ev_data};
        end
    end
    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 16'h0000;
`endif

    assign bus.load_wr   = r_load_wr;
    assign bus.load_addr = r_load_addr;
    assign bus.load_data = r_load_data;
    assign bus.load_done = (r_top == TOP_DONE);
    assign bus.sys_reset = (r_top != TOP_DONE);
    assign bus.rom_type  = r_rom_type;
    assign bus.rom_mask  = r_rom_mask;
    assign bus.ram_mask  = r_ram_mask;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire
